// File: rtl/mac_cfg_sequencer.sv
// Ethernet MAC control-port sequencer: fixed bring-up writes, SW_RESET poll, enable, then host pass-through.
// Optional readback check of the address/frame-length registers when MAC_CFG_VERIFY_EN is defined.
module mac_cfg_sequencer #(
  parameter logic [47:0] MAC_ADDR   = 48'h02_00_00_00_00_01,
  parameter int          MAX_FRAME  = 1518,
  parameter int          POLL_LIMIT = 16,
  parameter logic [31:0] CMD_ENABLE = 32'h0000_0003
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        done,
  output logic        error,
  output logic [7:0]  mac_addr,
  output logic        mac_rd,
  output logic        mac_wr,
  output logic [31:0] mac_wdata,
  input  logic [31:0] mac_rdata,
  input  logic        mac_busy,
  input  logic [7:0]  h_addr,
  input  logic        h_rd,
  input  logic        h_wr,
  input  logic [31:0] h_wdata,
  output logic [31:0] h_rdata,
  output logic        h_busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SEQ    = 3'd1;
  localparam logic [2:0] S_POLL   = 3'd2;
`ifdef MAC_CFG_VERIFY_EN
  localparam logic [2:0] S_VERIFY = 3'd3;
`endif
  localparam logic [2:0] S_EN     = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  // Station address: byte0 = MAC_ADDR[47:40] lands in the low byte of reg 0x03
  localparam logic [31:0] ADDR_LO = {MAC_ADDR[23:16], MAC_ADDR[31:24], MAC_ADDR[39:32], MAC_ADDR[47:40]};
  localparam logic [31:0] ADDR_HI = {16'h0, MAC_ADDR[7:0], MAC_ADDR[15:8]};
  localparam logic [31:0] FRM_LEN = 32'(MAX_FRAME);
  localparam logic [7:0]  POLL_LAST = 8'(POLL_LIMIT - 1);

  logic [2:0]  state;
  logic [2:0]  step;
  logic [7:0]  poll_cnt;
  logic        seq_rd, seq_wr;
  logic [7:0]  seq_addr;
  logic [31:0] seq_wdata;
  logic        restart_pend;

  logic        op_rd;
  logic [7:0]  op_addr;
  logic [31:0] op_wdata;

`ifdef MAC_CFG_VERIFY_EN
  logic [1:0]  vstep;
  logic [31:0] vexp;
  always_comb begin
    vexp = FRM_LEN;
    case (vstep)
      2'd0:    vexp = ADDR_LO;
      2'd1:    vexp = ADDR_HI;
      default: vexp = FRM_LEN;
    endcase
  end
`endif

  // Next own transfer for the current state/step
  always_comb begin
    op_rd    = 1'b0;
    op_addr  = 8'h02;
    op_wdata = 32'h0;
    case (state)
      S_SEQ: begin
        case (step)
          3'd0:    begin op_addr = 8'h02; op_wdata = 32'h0;       end
          3'd1:    begin op_addr = 8'h03; op_wdata = ADDR_LO;     end
          3'd2:    begin op_addr = 8'h04; op_wdata = ADDR_HI;     end
          3'd3:    begin op_addr = 8'h05; op_wdata = FRM_LEN;     end
          default: begin op_addr = 8'h02; op_wdata = 32'h2000;    end
        endcase
      end
      S_POLL: op_rd = 1'b1;
`ifdef MAC_CFG_VERIFY_EN
      S_VERIFY: begin
        op_rd   = 1'b1;
        op_addr = 8'h03 + {6'd0, vstep};
      end
`endif
      S_EN: op_wdata = CMD_ENABLE;
      default: ;
    endcase
  end

  wire host_pend = h_rd | h_wr;
  wire fwd       = (state == S_DONE) || (state == S_ERR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      step         <= 3'd0;
      poll_cnt     <= 8'd0;
      seq_rd       <= 1'b0;
      seq_wr       <= 1'b0;
      seq_addr     <= 8'h0;
      seq_wdata    <= 32'h0;
      done         <= 1'b0;
      error        <= 1'b0;
      restart_pend <= 1'b0;
`ifdef MAC_CFG_VERIFY_EN
      vstep        <= 2'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          state     <= S_SEQ;
          step      <= 3'd0;
          seq_wr    <= 1'b1;
          seq_addr  <= 8'h02;
          seq_wdata <= 32'h0;
        end
        S_DONE, S_ERR: begin
          // A pending host access finishes before the port is taken back
          if ((start || restart_pend) && !(host_pend && mac_busy)) begin
            done         <= 1'b0;
            error        <= 1'b0;
            restart_pend <= 1'b0;
            state        <= S_SEQ;
            step         <= 3'd0;
            seq_wr       <= 1'b1;
            seq_addr     <= 8'h02;
            seq_wdata    <= 32'h0;
          end else if (start) begin
            restart_pend <= 1'b1;
          end
        end
        default: begin
          if (!seq_rd && !seq_wr) begin
            seq_rd    <= op_rd;
            seq_wr    <= !op_rd;
            seq_addr  <= op_addr;
            seq_wdata <= op_wdata;
          end else if (!mac_busy) begin
            seq_rd <= 1'b0;
            seq_wr <= 1'b0;
            case (state)
              S_SEQ: begin
                if (step == 3'd4) begin
                  state    <= S_POLL;
                  poll_cnt <= 8'd0;
                end else if (step == 3'd3) begin
`ifdef MAC_CFG_VERIFY_EN
                  state <= S_VERIFY;
                  vstep <= 2'd0;
`else
                  step  <= 3'd4;
`endif
                end else begin
                  step <= step + 3'd1;
                end
              end
              S_POLL: begin
                if (!mac_rdata[13]) begin
                  state <= S_EN;
                end else if (poll_cnt == POLL_LAST) begin
                  state <= S_ERR;
                  error <= 1'b1;
                end else begin
                  poll_cnt <= poll_cnt + 8'd1;
                end
              end
`ifdef MAC_CFG_VERIFY_EN
              S_VERIFY: begin
                if (mac_rdata != vexp) begin
                  state <= S_ERR;
                  error <= 1'b1;
                end else if (vstep == 2'd2) begin
                  state <= S_SEQ;
                  step  <= 3'd4;
                end else begin
                  vstep <= vstep + 2'd1;
                end
              end
`endif
              S_EN: begin
                state <= S_DONE;
                done  <= 1'b1;
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  // Host owns the port only once the sequence has finished or failed
  assign mac_rd    = fwd ? h_rd : seq_rd;
  assign mac_wr    = fwd ? (h_wr & ~h_rd) : seq_wr;
  assign mac_addr  = fwd ? h_addr : seq_addr;
  assign mac_wdata = fwd ? h_wdata : seq_wdata;
  assign h_busy    = fwd ? mac_busy : 1'b1;
  assign h_rdata   = mac_rdata;

endmodule

// File: tb/tb_mac_cfg_sequencer.sv
// Directed bench for mac_cfg_sequencer with a small MAC register model, stall injector and transfer log.
module tb_mac_cfg_sequencer;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic        done, error, mac_rd, mac_wr, mac_busy, h_busy;
  logic [7:0]  mac_addr;
  logic [31:0] mac_wdata, mac_rdata, h_rdata;
  logic [7:0]  h_addr = 8'h0;
  logic        h_rd = 1'b0, h_wr = 1'b0;
  logic [31:0] h_wdata = 32'h0;

  mac_cfg_sequencer #(.POLL_LIMIT(4)) dut (
    .clk(clk), .reset(reset), .start(start), .done(done), .error(error),
    .mac_addr(mac_addr), .mac_rd(mac_rd), .mac_wr(mac_wr), .mac_wdata(mac_wdata),
    .mac_rdata(mac_rdata), .mac_busy(mac_busy),
    .h_addr(h_addr), .h_rd(h_rd), .h_wr(h_wr), .h_wdata(h_wdata),
    .h_rdata(h_rdata), .h_busy(h_busy)
  );

  always #5 clk = ~clk;

`ifdef MAC_CFG_VERIFY_EN
  localparam int NX = 10, POLL_IX = 8, DONE_CYC = 19;
  logic [7:0]  ex_addr [NX] = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h03, 8'h04, 8'h05, 8'h02, 8'h02, 8'h02};
  logic        ex_wr   [NX] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [31:0] ex_data [NX] = '{32'h0, 32'h2, 32'h100, 32'd1518, 32'h2, 32'h100, 32'd1518,
                                32'h2000, 32'h0, 32'h3};
`else
  localparam int NX = 7, POLL_IX = 5, DONE_CYC = 13;
  logic [7:0]  ex_addr [NX] = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h02, 8'h02, 8'h02};
  logic        ex_wr   [NX] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  logic [31:0] ex_data [NX] = '{32'h0, 32'h2, 32'h100, 32'd1518, 32'h2000, 32'h0, 32'h3};
`endif

  // MAC model: register file, scripted poll responses, optional bad readback of 0x05
  logic [31:0] regs [256];
  logic [31:0] poll_vals [4];
  int          poll_n = 0, poll_idx = 0;
  logic [31:0] poll_default = 32'h0;
  logic        poll_load = 1'b0, bad05 = 1'b0;
  logic [7:0]  stall_addr = 8'h0;
  int          stall_n = 0, stall_left = 0;
  logic        stall_load = 1'b0;
  int          cyc = -1;

  assign mac_busy = (stall_left > 0) && (mac_rd || mac_wr) && (mac_addr == stall_addr);

  always_comb begin
    mac_rdata = regs[mac_addr];
    if (mac_addr == 8'h02) mac_rdata = (poll_idx < poll_n) ? poll_vals[poll_idx] : poll_default;
    else if (mac_addr == 8'h05 && bad05) mac_rdata = 32'd1500;
  end

  always @(posedge clk) begin
    cyc <= reset ? -1 : cyc + 1;
    if (mac_wr && !mac_busy) regs[mac_addr] <= mac_wdata;
    if (poll_load) poll_idx <= 0;
    else if (mac_rd && !mac_busy && mac_addr == 8'h02) poll_idx <= poll_idx + 1;
    if (stall_load) stall_left <= stall_n;
    else if (mac_busy) stall_left <= stall_left - 1;
  end

  // Transfer log, sampled on the falling edge
  logic [7:0]  log_addr [64];
  logic        log_wr   [64];
  logic [31:0] log_data [64];
  int          log_cyc  [64];
  int          log_n = 0, stab_cnt = 0, hb_viol = 0, both_cnt = 0;

  always @(negedge clk) begin
    if (reset) begin
      log_n    <= 0;
      stab_cnt <= 0;
      hb_viol  <= 0;
    end else begin
      if ((mac_rd || mac_wr) && !mac_busy && log_n < 64) begin
        log_addr[log_n] <= mac_addr;
        log_wr[log_n]   <= mac_wr;
        log_data[log_n] <= mac_wr ? mac_wdata : mac_rdata;
        log_cyc[log_n]  <= cyc;
        log_n           <= log_n + 1;
      end
      if (mac_wr && mac_addr == 8'h03 && mac_wdata == 32'h2) stab_cnt <= stab_cnt + 1;
      if (!h_busy && !done && !error) hb_viol <= hb_viol + 1;
    end
    if (mac_rd && mac_wr) both_cnt <= both_cnt + 1;
  end

  int ncmp = 0, nfail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int maxc);
    int i = 0;
    @(negedge clk);
    while (!(done || error) && i < maxc) begin
      @(negedge clk);
      i++;
    end
    chk("wait_done_timeout", {63'd0, done || error}, 64'd1);
  endtask

  task automatic set_stall(input logic [7:0] a, input int n);
    stall_addr = a;
    stall_n    = n;
    stall_load = 1'b1;
    @(posedge clk); #1;
    stall_load = 1'b0;
  endtask

  task automatic load_poll(input int n, input logic [31:0] dflt);
    poll_n       = n;
    poll_default = dflt;
    poll_load    = 1'b1;
    @(posedge clk); #1;
    poll_load    = 1'b0;
  endtask

  initial begin
    int base, i, n4;
    // Reset values, host already requesting a read of 0x05
    h_rd = 1'b1; h_addr = 8'h05;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_mac_rd", mac_rd, 0);
    chk("rst_mac_wr", mac_wr, 0);
    chk("rst_mac_addr", mac_addr, 0);
    chk("rst_mac_wdata", mac_wdata, 0);
    chk("rst_h_busy", h_busy, 1);

    // Nominal bring-up; host read waits for done
    @(posedge clk); #1 reset = 1'b0;
    wait_done(200);
    chk("t1_done_cycle", cyc, DONE_CYC);
    chk("t1_done", done, 1);
    chk("t1_error", error, 0);
    chk("t5_h_busy_at_done", h_busy, 0);
    chk("t5_h_rdata", h_rdata, 32'd1518);
    @(posedge clk); #1 h_rd = 1'b0;
    for (int k = 0; k < NX; k++) begin
      chk($sformatf("t1_addr%0d", k), log_addr[k], ex_addr[k]);
      chk($sformatf("t1_wr%0d", k), log_wr[k], ex_wr[k]);
      chk($sformatf("t1_data%0d", k), log_data[k], ex_data[k]);
      chk($sformatf("t1_cyc%0d", k), log_cyc[k], 2 * k);
    end
    chk("t5_host_addr", log_addr[NX], 8'h05);
    chk("t5_host_data", log_data[NX], 32'd1518);
    chk("t5_host_cyc", log_cyc[NX], DONE_CYC);
    chk("t1_log_n", log_n, NX + 1);
    chk("t5_locked_out", hb_viol, 0);

    // Stall on W03
    reset = 1'b1;
    set_stall(8'h03, 3);
    @(posedge clk); #1 reset = 1'b0;
    wait_done(200);
    chk("t2_done_cycle", cyc, DONE_CYC + 3);
    chk("t2_w03_addr", log_addr[1], 8'h03);
    chk("t2_w03_cyc", log_cyc[1], 5);
    chk("t2_next_cyc", log_cyc[2], 7);
    chk("t2_stable_cycles", stab_cnt, 4);

    // Poll returns busy twice, then clear
    reset = 1'b1;
    poll_vals[0] = 32'h2000; poll_vals[1] = 32'h2000; poll_vals[2] = 32'h0;
    load_poll(3, 32'h0);
    @(posedge clk); #1 reset = 1'b0;
    wait_done(200);
    chk("t3_done", done, 1);
    chk("t3_log_n", log_n, NX + 2);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("t3_rd%0d_addr", k), log_addr[POLL_IX + k], 8'h02);
      chk($sformatf("t3_rd%0d_wr", k), log_wr[POLL_IX + k], 0);
    end
    chk("t3_en_wr", log_wr[POLL_IX + 3], 1);
    chk("t3_en_data", log_data[POLL_IX + 3], 32'h3);

    // Poll never clears: error after 4 reads
    reset = 1'b1;
    load_poll(0, 32'h2000);
    @(posedge clk); #1 reset = 1'b0;
    wait_done(200);
    chk("t4_error", error, 1);
    chk("t4_done", done, 0);
    @(posedge clk); #1;
    n4 = log_n;
    chk("t4_log_n", n4, POLL_IX + 4);
    chk("t4_last_is_read", log_wr[n4 - 1], 0);
    repeat (3) @(negedge clk);
    chk("t4_no_en_write", log_n, n4);
    @(posedge clk); #1 h_rd = 1'b1; h_addr = 8'h02;
    @(negedge clk);
    chk("t4_fwd_rd", mac_rd, 1);
    chk("t4_fwd_addr", mac_addr, 8'h02);
    chk("t4_fwd_busy", h_busy, 0);
    chk("t4_fwd_rdata", h_rdata, 32'h2000);
    @(posedge clk); #1 h_rd = 1'b0;

    // Restart deferred behind a stalled host write
    poll_default = 32'h0;
`ifdef MAC_CFG_VERIFY_EN
    bad05 = 1'b1;
`endif
    set_stall(8'h10, 5);
    base = log_n;
    h_wr = 1'b1; h_addr = 8'h10; h_wdata = 32'hA5;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    i = 0;
    @(negedge clk);
    while (mac_busy && i < 50) begin
      @(negedge clk);
      i++;
    end
    chk("t6_stall_timeout", {63'd0, mac_busy}, 64'd0);
    @(posedge clk); #1 h_wr = 1'b0;
    @(negedge clk);
    chk("t6_err_cleared", error, 0);
    chk("t6_first_wr", mac_wr, 1);
    chk("t6_first_addr", mac_addr, 8'h02);
    chk("t6_first_data", mac_wdata, 32'h0);
    wait_done(200);
    @(posedge clk); #1;
    chk("t6_host_addr", log_addr[base], 8'h10);
    chk("t6_host_data", log_data[base], 32'hA5);
    chk("t6_seq_addr", log_addr[base + 1], 8'h02);
    chk("t6_seq_gap", log_cyc[base + 1] - log_cyc[base], 1);
    chk("t6_xfer_count", log_n - base, 8);
`ifdef MAC_CFG_VERIFY_EN
    chk("t6_verify_error", error, 1);
    chk("t6_verify_done", done, 0);
`else
    chk("t6_done", done, 1);
    chk("t6_error", error, 0);
`endif
    chk("rd_wr_exclusive", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
